// File: rtl/mem_access_stage.sv
// Memory stage: drives a req/ack data-memory transaction and stalls upstream.
// Optional MEM_TIMEOUT_EN: forced completion after TIMEOUT BUSY cycles.
module mem_access_stage #(
    parameter int DATA_W      = 16,
    parameter int STALL_CNT_W = 16
`ifdef MEM_TIMEOUT_EN
    ,
    parameter int TIMEOUT     = 255
`endif
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   mem_read_in,
    input  logic                   mem_write_in,
    input  logic [DATA_W-1:0]      alu_result_in,
    input  logic [DATA_W-1:0]      store_data_in,
    input  logic [3:0]             dstReg_in,
    input  logic                   reg_write_in,
    output logic                   dmem_req,
    output logic                   dmem_we,
    output logic [DATA_W-1:0]      dmem_addr,
    output logic [DATA_W-1:0]      dmem_wdata,
    input  logic                   dmem_ack,
    input  logic [DATA_W-1:0]      dmem_rdata,
    output logic                   stall_out,
    output logic [DATA_W-1:0]      read_data_out,
    output logic [DATA_W-1:0]      alu_result_out,
    output logic [3:0]             dstReg_out,
    output logic                   reg_write_out,
    output logic [STALL_CNT_W-1:0] stall_cycles
`ifdef MEM_TIMEOUT_EN
    ,
    output logic                   timeout_err
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e state_q, state_d;

    logic                   we_q, we_d;
    logic                   load_q, load_d;
    logic [DATA_W-1:0]      addr_q, addr_d;
    logic [DATA_W-1:0]      wdata_q, wdata_d;
    logic [DATA_W-1:0]      rdata_q, rdata_d;
    logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    logic access;
    logic tmo_hit;

    // Gated by rst_n so a held EX/MEM access cannot raise req during reset.
    assign access = (mem_read_in | mem_write_in) & rst_n;

`ifdef MEM_TIMEOUT_EN
    logic [7:0] tmo_cnt_q, tmo_cnt_d;
    logic       tmo_err_q, tmo_err_d;

    assign tmo_hit = (state_q == BUSY) && !dmem_ack
                     && (tmo_cnt_q == 8'(TIMEOUT - 1));

    always_comb begin
        tmo_cnt_d = 8'd0;
        if (state_q == BUSY) begin
            tmo_cnt_d = tmo_cnt_q + 8'd1;
        end
        tmo_err_d = tmo_err_q | tmo_hit;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt_q <= 8'd0;
            tmo_err_q <= 1'b0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            tmo_err_q <= tmo_err_d;
        end
    end

    assign timeout_err = tmo_err_q;
`else
    assign tmo_hit = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (access) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (dmem_ack || tmo_hit) begin
                    state_d = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        we_d    = we_q;
        load_d  = load_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        if (state_q == IDLE && access) begin
            we_d    = mem_write_in;
            load_d  = ~mem_write_in;
            addr_d  = alu_result_in;
            wdata_d = store_data_in;
        end
        if (state_q == BUSY) begin
            if (dmem_ack) begin
                rdata_d = load_q ? dmem_rdata : '0;
            end else if (tmo_hit) begin
                rdata_d = '1;
            end
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_out && !(&stall_cnt_q)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q        <= 1'b0;
            load_q      <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            stall_cnt_q <= '0;
        end else begin
            we_q        <= we_d;
            load_q      <= load_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    always_comb begin
        dmem_req      = 1'b0;
        dmem_we       = 1'b0;
        dmem_addr     = '0;
        dmem_wdata    = '0;
        stall_out     = 1'b0;
        read_data_out = '0;
        unique case (state_q)
            IDLE: begin
                if (access) begin
                    dmem_req   = 1'b1;
                    dmem_we    = mem_write_in;
                    dmem_addr  = alu_result_in;
                    dmem_wdata = store_data_in;
                    stall_out  = 1'b1;
                end
            end
            BUSY: begin
                dmem_req   = 1'b1;
                dmem_we    = we_q;
                dmem_addr  = addr_q;
                dmem_wdata = wdata_q;
                stall_out  = 1'b1;
            end
            DONE: read_data_out = rdata_q;
            default: ;
        endcase
    end

    assign reg_write_out  = reg_write_in & ~stall_out;
    assign alu_result_out = alu_result_in;
    assign dstReg_out     = dstReg_in;
    assign stall_cycles   = stall_cnt_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage with a read-data scoreboard.
// A 4-bit-counter twin shares the stimulus to exercise saturation.
module tb_mem_access_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read_in, mem_write_in;
    logic [15:0] alu_result_in, store_data_in;
    logic [3:0]  dstReg_in;
    logic        reg_write_in;
    logic        dmem_req, dmem_we;
    logic [15:0] dmem_addr, dmem_wdata;
    logic        dmem_ack;
    logic [15:0] dmem_rdata;
    logic        stall_out;
    logic [15:0] read_data_out, alu_result_out;
    logic [3:0]  dstReg_out;
    logic        reg_write_out;
    logic [15:0] stall_cycles;

    logic        s_req, s_we, s_stall, s_rwo;
    logic [15:0] s_addr, s_wdata, s_rd, s_alu;
    logic [3:0]  s_dst;
    logic [3:0]  s_cycles;
`ifdef MEM_TIMEOUT_EN
    logic        timeout_err, s_tmo;
`endif

    int n_checks = 0;
    int n_err    = 0;
    logic [15:0] sb[$];

    always #5 clk = ~clk;

    mem_access_stage #(
        .DATA_W(16), .STALL_CNT_W(16)
`ifdef MEM_TIMEOUT_EN
        , .TIMEOUT(8)
`endif
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .alu_result_in(alu_result_in), .store_data_in(store_data_in),
        .dstReg_in(dstReg_in), .reg_write_in(reg_write_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall_out(stall_out), .read_data_out(read_data_out),
        .alu_result_out(alu_result_out), .dstReg_out(dstReg_out),
        .reg_write_out(reg_write_out), .stall_cycles(stall_cycles)
`ifdef MEM_TIMEOUT_EN
        , .timeout_err(timeout_err)
`endif
    );

    mem_access_stage #(
        .DATA_W(16), .STALL_CNT_W(4)
`ifdef MEM_TIMEOUT_EN
        , .TIMEOUT(8)
`endif
    ) sat (
        .clk(clk), .rst_n(rst_n),
        .mem_read_in(mem_read_in), .mem_write_in(mem_write_in),
        .alu_result_in(alu_result_in), .store_data_in(store_data_in),
        .dstReg_in(dstReg_in), .reg_write_in(reg_write_in),
        .dmem_req(s_req), .dmem_we(s_we),
        .dmem_addr(s_addr), .dmem_wdata(s_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall_out(s_stall), .read_data_out(s_rd),
        .alu_result_out(s_alu), .dstReg_out(s_dst),
        .reg_write_out(s_rwo), .stall_cycles(s_cycles)
`ifdef MEM_TIMEOUT_EN
        , .timeout_err(s_tmo)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pop_chk(input string tag);
        logic [15:0] e;
        n_checks++;
        if (sb.size() == 0) begin
            n_err++;
            $error("FAIL %s: observed empty scoreboard expected entry", tag);
        end else begin
            e = sb.pop_front();
            assert (read_data_out === e) else begin
                n_err++;
                $error("FAIL %s: observed %h expected %h",
                       tag, read_data_out, e);
            end
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        mem_read_in = 0; mem_write_in = 0;
        alu_result_in = '0; store_data_in = '0;
        dstReg_in = '0; reg_write_in = 0;
        dmem_ack = 0; dmem_rdata = '0;
        #3;
        chk("rst_req", dmem_req, 0);
        chk("rst_we", dmem_we, 0);
        chk("rst_stall", stall_out, 0);
        chk("rst_addr", dmem_addr, 0);
        chk("rst_wdata", dmem_wdata, 0);
        chk("rst_rd", read_data_out, 0);
        chk("rst_cnt", stall_cycles, 0);
        @(negedge clk); rst_n = 1'b1;

        // plain ALU op
        @(negedge clk);
        alu_result_in = 16'h1234; dstReg_in = 4'd5; reg_write_in = 1;
        #1;
        chk("alu_req", dmem_req, 0);
        chk("alu_stall", stall_out, 0);
        chk("alu_res", alu_result_out, 16'h1234);
        chk("alu_dst", dstReg_out, 5);
        chk("alu_rw", reg_write_out, 1);
        chk("alu_rd", read_data_out, 0);

        // load acked in first BUSY cycle
        @(negedge clk);
        mem_read_in = 1; alu_result_in = 16'h0040; dstReg_in = 4'd3;
        sb.push_back(16'hBEEF);
        #1;
        chk("ld_c0_req", dmem_req, 1);
        chk("ld_c0_stall", stall_out, 1);
        chk("ld_c0_we", dmem_we, 0);
        chk("ld_c0_addr", dmem_addr, 16'h0040);
        chk("ld_c0_rw", reg_write_out, 0);
        @(negedge clk); dmem_ack = 1; dmem_rdata = 16'hBEEF; #1;
        chk("ld_c1_req", dmem_req, 1);
        chk("ld_c1_stall", stall_out, 1);
        chk("ld_c1_addr", dmem_addr, 16'h0040);
        @(negedge clk); dmem_ack = 0; dmem_rdata = '0; #1;
        chk("ld_c2_stall", stall_out, 0);
        chk("ld_c2_req", dmem_req, 0);
        chk("ld_c2_rw", reg_write_out, 1);
        pop_chk("ld_c2_rd");
        chk("ld_cnt", stall_cycles, 2);

        // store, ack on 4th BUSY cycle; inputs change but must be ignored
        @(negedge clk);
        mem_read_in = 0; mem_write_in = 1;
        alu_result_in = 16'h0100; store_data_in = 16'hA5A5;
        sb.push_back(16'h0000);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) begin
                @(negedge clk);
                alu_result_in = 16'hDEAD; store_data_in = 16'h0000;
                dmem_ack = (i == 4);
            end
            #1;
            chk($sformatf("st_req%0d", i), dmem_req, 1);
            chk($sformatf("st_we%0d", i), dmem_we, 1);
            chk($sformatf("st_addr%0d", i), dmem_addr, 16'h0100);
            chk($sformatf("st_wd%0d", i), dmem_wdata, 16'hA5A5);
            chk($sformatf("st_rw%0d", i), reg_write_out, 0);
        end
        @(negedge clk); dmem_ack = 0; #1;
        chk("st_done_req", dmem_req, 0);
        chk("st_done_stall", stall_out, 0);
        pop_chk("st_done_rd");
        chk("st_cnt", stall_cycles, 7);

        // back-to-back loads with spurious ack in DONE
        @(negedge clk);
        mem_write_in = 0; mem_read_in = 1; alu_result_in = 16'h0010;
        sb.push_back(16'h1111);
        #1;
        chk("bb1_req", dmem_req, 1);
        @(negedge clk); dmem_ack = 1; dmem_rdata = 16'h1111;
        @(negedge clk); dmem_ack = 1; dmem_rdata = 16'h9999; #1;
        chk("bb1_done_req", dmem_req, 0);
        chk("bb1_done_stall", stall_out, 0);
        pop_chk("bb1_rd");
        @(negedge clk);
        dmem_ack = 0; alu_result_in = 16'h0020;
        sb.push_back(16'h2222);
        #1;
        chk("bb2_req", dmem_req, 1);
        chk("bb2_addr", dmem_addr, 16'h0020);
        chk("bb2_stall", stall_out, 1);
        @(negedge clk); dmem_ack = 1; dmem_rdata = 16'h2222;
        @(negedge clk); dmem_ack = 0; #1;
        chk("bb2_stall_dn", stall_out, 0);
        pop_chk("bb2_rd");
        chk("bb_cnt", stall_cycles, 11);
        chk("sat_cnt_b", s_cycles, 4'hB);

        // ten more quick loads push the 4-bit twin into saturation
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            alu_result_in = 16'h0300 + 16'(k);
            sb.push_back(16'hC000 + 16'(k));
            @(negedge clk); dmem_ack = 1; dmem_rdata = 16'hC000 + 16'(k);
            @(negedge clk); dmem_ack = 0; #1;
            pop_chk($sformatf("sat_rd%0d", k));
        end
        @(negedge clk); mem_read_in = 0; #1;
        chk("sat_main_cnt", stall_cycles, 31);
        chk("sat_twin_cnt", s_cycles, 4'hF);

`ifdef MEM_TIMEOUT_EN
        // load never acked: forced DONE after 8 BUSY cycles
        @(negedge clk);
        mem_read_in = 1; alu_result_in = 16'h0500;
        sb.push_back(16'hFFFF);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
        end
        #1;
        chk("tmo_busy8", stall_out, 1);
        chk("tmo_err0", timeout_err, 0);
        @(negedge clk); #1;
        chk("tmo_done", stall_out, 0);
        pop_chk("tmo_rd");
        chk("tmo_err1", timeout_err, 1);
        @(negedge clk); mem_read_in = 0; #1;
        chk("tmo_sticky", timeout_err, 1);
        chk("tmo_cnt", stall_cycles, 40);
`endif

        // reset in the middle of BUSY
        @(negedge clk);
        mem_read_in = 1; alu_result_in = 16'h0777;
        @(negedge clk); #1;
        chk("mid_busy_req", dmem_req, 1);
        rst_n = 1'b0; #1;
        chk("mid_rst_req", dmem_req, 0);
        chk("mid_rst_stall", stall_out, 0);
        chk("mid_rst_addr", dmem_addr, 0);
        chk("mid_rst_cnt", stall_cycles, 0);
`ifdef MEM_TIMEOUT_EN
        chk("mid_rst_tmo", timeout_err, 0);
`endif
        @(negedge clk); rst_n = 1'b1; mem_read_in = 0; #1;
        chk("post_rst_req", dmem_req, 0);
        chk("post_rst_stall", stall_out, 0);
        @(negedge clk);
        mem_read_in = 1; alu_result_in = 16'h0888;
        sb.push_back(16'h4321);
        #1;
        chk("post_ld_req", dmem_req, 1);
        chk("post_ld_addr", dmem_addr, 16'h0888);
        @(negedge clk); dmem_ack = 1; dmem_rdata = 16'h4321;
        @(negedge clk); dmem_ack = 0; mem_read_in = 0; #1;
        pop_chk("post_ld_rd");
        chk("post_ld_cnt", stall_cycles, 2);
        chk("sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory stage of the 16-bit pipelined CPU. Sits between the EX/MEM pipeline register and the MEM/WB pipeline register.
- Turns load/store requests from EX/MEM into a req/ack transaction on a variable-latency data memory.
- Stalls the upstream pipeline until the access completes.
- Presents read data, the ALU result pass-through, the destination register and a write-enable to MEM/WB. While stalled, MEM/WB receives a bubble.

Parameters:
- DATA_W, 16, data and address width
- STALL_CNT_W, 16, width of the saturating stall-cycle performance counter
- TIMEOUT, 255, max BUSY cycles before forced completion (optional feature only)

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- mem_read_in  in  1  EX/MEM: load
- mem_write_in  in  1  EX/MEM: store
- alu_result_in  in  DATA_W  EX/MEM: address / ALU value
- store_data_in  in  DATA_W  EX/MEM: store data
- dstReg_in  in  4  EX/MEM: destination register
- reg_write_in  in  1  EX/MEM: register write enable
- dmem_req  out  1  memory request
- dmem_we  out  1  1 = write
- dmem_addr  out  DATA_W  memory address
- dmem_wdata  out  DATA_W  memory write data
- dmem_ack  in  1  memory done (read data valid same cycle)
- dmem_rdata  in  DATA_W  memory read data
- stall_out  out  1  freeze PC/IF/ID/EX/EX-MEM
- read_data_out  out  DATA_W  to MEM/WB
- alu_result_out  out  DATA_W  to MEM/WB
- dstReg_out  out  4  to MEM/WB
- reg_write_out  out  1  to MEM/WB, bubbled when stalled
- stall_cycles  out  STALL_CNT_W  saturating count of stall cycles

Behaviour:
- Clock and reset: single clock clk. Reset rst_n is asynchronous, active-low.
- Reset forces the following immediately, with no clock needed:
  - state = IDLE
  - dmem_req = 0, dmem_we = 0
  - dmem_addr, dmem_wdata, read_data_out = 0
  - stall_cycles = 0
- access = mem_read_in | mem_write_in. If both are asserted, treat the access as a store.
- State IDLE:
  - If access: dmem_req = 1 combinationally. dmem_we = mem_write_in. dmem_addr = alu_result_in. dmem_wdata = store_data_in. stall_out = 1. Capture addr/wdata/we; next state BUSY.
  - If no access: stall_out = 0, and all EX/MEM values pass through combinationally. read_data_out = 0.
- State BUSY:
  - dmem_req = 1 and stall_out = 1. Address, write data and we are driven from the captured registers.
  - Inputs from EX/MEM are ignored; they are frozen by the stall.
  - On dmem_ack: capture dmem_rdata (loads only; stores capture 0) into rdata_q; next state DONE.
  - Otherwise remain in BUSY.
- State DONE:
  - dmem_req = 0, stall_out = 0, read_data_out = rdata_q.
  - The still-asserted EX/MEM access is NOT reissued.
  - Next state IDLE unconditionally.
- Latency: minimum access is 3 cycles (IDLE, BUSY with ack, DONE). Each extra cycle without ack adds one BUSY cycle.
- reg_write_out = reg_write_in & ~stall_out. alu_result_out and dstReg_out always pass through.
- stall_cycles increments on every cycle with stall_out = 1 and saturates at all-ones.
- A dmem_ack in IDLE or DONE is ignored.
- Reset mid-BUSY: dmem_req drops asynchronously and the outstanding access is abandoned.

Optional Feature:
- Macro: MEM_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entering BUSY and increments each BUSY cycle.
  - If the count reaches TIMEOUT with no ack, the block forces DONE with rdata_q = all-ones (16'hFFFF).
  - It also sets a sticky timeout_err output (1 bit, cleared only by reset).
- Not defined: no counter and no timeout_err port. BUSY waits indefinitely.

Test Plan:
- Reset mid-BUSY: assert rst_n = 0 while in BUSY -> dmem_req = 0 and stall_out = 0 in the same cycle; state IDLE after release.
- ALU op: mem_read = mem_write = 0, alu_result_in = 16'h1234, dstReg_in = 5, reg_write = 1 -> no req, stall_out = 0, alu_result_out = 16'h1234, reg_write_out = 1, read_data_out = 0.
- Load, ack in first BUSY cycle: mem_read = 1, addr 16'h0040, dmem_rdata = 16'hBEEF:
  - cycle 0: req = 1, stall = 1
  - cycle 1: ack, stall = 1
  - cycle 2: stall = 0, read_data_out = 16'hBEEF, reg_write_out = 1
  - stall_cycles = 2
- Store with 4-cycle ack delay: addr 16'h0100, data 16'hA5A5:
  - dmem_we = 1 and addr/wdata held stable for all 5 request cycles
  - reg_write_out = 0 throughout the stall
  - single transaction only; no reissue in DONE
- Back-to-back loads: second load is presented the cycle after DONE -> new req in IDLE. Spurious ack during DONE is ignored.
- Saturation: with STALL_CNT_W = 4, 20 stall cycles -> stall_cycles = 4'hF.
- With MEM_TIMEOUT_EN defined and TIMEOUT = 8, load never acked -> DONE after 8 BUSY cycles, read_data_out = 16'hFFFF, timeout_err = 1 until reset.
